// File: rtl/stream_unpack.sv
// Wide-to-narrow stream unpacker: one width_p*ratio_p word in, ratio_p width_p beats out.
// Define STREAM_UNPACK_MSB_FIRST_EN to emit the most-significant beat first (LSB first otherwise).
module stream_unpack #(
  parameter int unsigned width_p = 8,
  parameter int unsigned ratio_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p*ratio_p-1:0] data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  localparam int unsigned BeatW = (ratio_p > 1) ? $clog2(ratio_p) : 1;
  localparam int Ratio = int'(ratio_p);
  localparam int Width = int'(width_p);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(ratio_p - 1);

  logic [width_p*ratio_p-1:0] hold_q;
  logic                       full_q;
  logic [BeatW-1:0]           beat_q;
  logic                       last_beat;
  logic                       in_xfer;
  logic                       out_xfer;

  assign last_beat = (beat_q == LastBeat);
  // Accept the next word in the same cycle the last beat leaves.
  assign ready_o   = ~full_q | (ready_i & last_beat);
  assign valid_o   = full_q;
  assign in_xfer   = valid_i & ready_o;
  assign out_xfer  = full_q & ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q <= '0;
      full_q <= 1'b0;
      beat_q <= '0;
    end else if (in_xfer) begin
      hold_q <= data_i;
      full_q <= 1'b1;
      beat_q <= '0;
    end else if (out_xfer) begin
      if (last_beat) begin
        full_q <= 1'b0;
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < Ratio; i++) begin
      if (beat_q == BeatW'(i)) begin
`ifdef STREAM_UNPACK_MSB_FIRST_EN
        data_o = hold_q[(Ratio-1-i)*Width +: Width];
`else
        data_o = hold_q[i*Width +: Width];
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_unpack.sv
// Bench for stream_unpack: directed scenarios plus random traffic against a beat-queue model,
// for a 4:1 instance and a 1:1 (register slice) instance.
module tb_stream_unpack;

`ifdef STREAM_UNPACK_MSB_FIRST_EN
  localparam bit Msb = 1'b1;
`else
  localparam bit Msb = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] data4;
  logic        valid4, ready4_in;
  logic        ready4_out, valid4_out;
  logic [7:0]  data4_out;
  logic [7:0]  data1;
  logic        valid1, ready1_in;
  logic        ready1_out, valid1_out;
  logic [7:0]  data1_out;

  int total = 0;
  int bad = 0;
  logic [7:0] q4[$];
  logic [7:0] q1[$];
  logic [7:0] e028[4];
  logic [7:0] e031[4];

  always #5 clk = ~clk;

  stream_unpack #(.width_p(8), .ratio_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .data_i(data4), .valid_i(valid4), .ready_o(ready4_out),
    .data_o(data4_out), .valid_o(valid4_out), .ready_i(ready4_in)
  );

  stream_unpack #(.width_p(8), .ratio_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data1), .valid_i(valid1), .ready_o(ready1_out),
    .data_o(data1_out), .valid_o(valid1_out), .ready_i(ready1_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs after the edge, check outputs against the queues, advance the model.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic v1, input logic [7:0] d1, input logic r1);
    logic ev, er, ev1, er1;
    @(posedge clk); #1;
    valid4 = v; data4 = d; ready4_in = r;
    valid1 = v1; data1 = d1; ready1_in = r1;
    #1;
    ev = (q4.size() != 0);
    er = (q4.size() == 0) || (r && q4.size() == 1);
    chk("valid_o", {31'b0, valid4_out}, {31'b0, ev});
    chk("ready_o", {31'b0, ready4_out}, {31'b0, er});
    if (ev) chk("data_o", {24'b0, data4_out}, {24'b0, q4[0]});
    ev1 = (q1.size() != 0);
    er1 = (q1.size() == 0) || r1;
    chk("r1_valid_o", {31'b0, valid1_out}, {31'b0, ev1});
    chk("r1_ready_o", {31'b0, ready1_out}, {31'b0, er1});
    if (ev1) chk("r1_data_o", {24'b0, data1_out}, {24'b0, q1[0]});
    if (ev && r) void'(q4.pop_front());
    if (v && er)
      for (int k = 0; k < 4; k++) q4.push_back(Msb ? d[8*(3-k) +: 8] : d[8*k +: 8]);
    if (ev1 && r1) void'(q1.pop_front());
    if (v1 && er1) q1.push_back(d1);
  endtask

  task automatic idle4(input logic r);
    step(1'b0, 32'h0, r, 1'b0, 8'h0, 1'b1);
  endtask

  initial begin
    e028 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
    e031 = '{8'h44, 8'h33, 8'h22, 8'h11};
    reset_i = 1'b1;
    valid4 = 1'b0; data4 = 32'h0; ready4_in = 1'b1;
    valid1 = 1'b0; data1 = 8'h0; ready1_in = 1'b1;
    #3;
    chk("rst_valid_o", {31'b0, valid4_out}, 32'd0);
    chk("rst_data_o", {24'b0, data4_out}, 32'd0);
    chk("rst_ready_o", {31'b0, ready4_out}, 32'd1);
    chk("rst_r1_valid_o", {31'b0, valid1_out}, 32'd0);
    chk("rst_r1_ready_o", {31'b0, ready1_out}, 32'd1);
    @(posedge clk); #1;
    reset_i = 1'b0;

    // Single word, free-flowing sink.
    step(1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle4(1'b1);
      chk("single_beat", {24'b0, data4_out}, {24'b0, e028[Msb ? 3-k : k]});
    end
    idle4(1'b1);
    chk("single_done", {31'b0, valid4_out}, 32'd0);

    // Back-to-back words with valid held: zero-bubble handoff on the 4th beat.
    step(1'b1, 32'h04030201, 1'b1, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(k < 4, 32'h08070605, 1'b1, 1'b0, 8'h0, 1'b1);
      chk("b2b_valid", {31'b0, valid4_out}, 32'd1);
      chk("b2b_beat", {24'b0, data4_out},
          (k < 4) ? (Msb ? 32'(4 - k) : 32'(k + 1)) : (Msb ? 32'(12 - k) : 32'(k + 1)));
      if (k == 3) chk("b2b_ready_c4", {31'b0, ready4_out}, 32'd1);
    end
    idle4(1'b1);
    chk("b2b_done", {31'b0, valid4_out}, 32'd0);

    // Stall for three cycles on beat 1.
    step(1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h0, 1'b1);
    idle4(1'b1);
    for (int k = 0; k < 3; k++) begin
      idle4(1'b0);
      chk("stall_hold", {24'b0, data4_out}, {24'b0, e028[Msb ? 2 : 1]});
      chk("stall_ready", {31'b0, ready4_out}, 32'd0);
    end
    idle4(1'b1);
    chk("stall_resume_c", {24'b0, data4_out}, {24'b0, e028[Msb ? 2 : 1]});
    idle4(1'b1);
    chk("stall_resume_b", {24'b0, data4_out}, {24'b0, e028[Msb ? 1 : 2]});
    idle4(1'b1);
    idle4(1'b1);
    chk("stall_done", {31'b0, valid4_out}, 32'd0);

    // Reset mid-word discards the remaining beats without a clock edge.
    step(1'b1, 32'hAABBCCDD, 1'b1, 1'b0, 8'h0, 1'b1);
    idle4(1'b1);
    chk("pre_rst_beat", {24'b0, data4_out}, {24'b0, e028[Msb ? 3 : 0]});
    #2;
    reset_i = 1'b1;
    #1;
    chk("midrst_valid_o", {31'b0, valid4_out}, 32'd0);
    chk("midrst_ready_o", {31'b0, ready4_out}, 32'd1);
    q4.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    idle4(1'b1);
    chk("post_rst_idle", {31'b0, valid4_out}, 32'd0);
    step(1'b1, 32'h11223344, 1'b1, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      idle4(1'b1);
      chk("post_rst_beat", {24'b0, data4_out}, {24'b0, e031[Msb ? 3-k : k]});
    end
    idle4(1'b1);
    chk("post_rst_done", {31'b0, valid4_out}, 32'd0);

    // Random traffic on both instances.
    for (int c = 0; c < 1000; c++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Drain and confirm nothing is left or duplicated.
    for (int c = 0; c < 8; c++) step(1'b0, 32'h0, 1'b1, 1'b0, 8'h0, 1'b1);
    chk("drain_valid", {31'b0, valid4_out}, 32'd0);
    chk("drain_r1_valid", {31'b0, valid1_out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_unpack.md
STREAM_UNPACK -- requirements
Module: stream_unpack

Interface
REQ-001 Parameter width_p: default 8; width of one output beat in bits (>=1).
REQ-002 Parameter ratio_p: default 4; output beats per input word (>=1).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 data_i  input  width_p*ratio_p  packed input word.
REQ-006 valid_i  input  1  data_i is valid.
REQ-007 ready_o  output  1  block accepts data_i this cycle.
REQ-008 data_o  output  width_p  current output beat.
REQ-009 valid_o  output  1  data_o is valid.
REQ-010 ready_i  input  1  downstream accepts data_o this cycle.

Function
REQ-011 The block SHALL contain one width_p*ratio_p holding register, a full flag, and a beat counter of clog2(ratio_p) bits (min 1 bit).
REQ-012 An input transfer SHALL occur when valid_i & ready_o; an output transfer SHALL occur when valid_o & ready_i.
REQ-013 valid_o SHALL equal the full flag, with no combinational path from valid_i.
REQ-014 ready_o SHALL be ~full | (ready_i & beat == ratio_p-1), so the next word is accepted in the cycle the last beat leaves (zero-bubble).
REQ-015 On an input transfer, the block SHALL load the holding register, set full, and clear the beat counter; data_o is valid the next cycle (latency 1).
REQ-016 On an output transfer with beat < ratio_p-1, the beat counter SHALL increment by 1.
REQ-017 On an output transfer with beat == ratio_p-1 and no simultaneous input transfer, full SHALL clear and the counter SHALL return to 0.
REQ-018 A simultaneous last-beat output transfer and input transfer SHALL load the new word, keep full set, and reset the beat to 0.
REQ-019 While valid_o & ~ready_i, data_o, valid_o, and the beat counter SHALL hold stable.
REQ-020 data_o SHALL be the holding register slice [beat*width_p +: width_p] by default (LSB first).
REQ-021 With ratio_p == 1, the block SHALL act as a one-entry register slice: ready_o = ~full | ready_i, and data_o = the full register.
REQ-022 valid_i asserted while ready_o is low SHALL have no effect; data_i is not sampled.

Reset
REQ-023 While reset_i is high, full SHALL be 0, the beat counter 0, and the holding register 0. Outputs: valid_o=0, data_o=0, ready_o=1.
REQ-024 Asserting reset mid-word SHALL discard all undelivered beats. After release, no partial beat SHALL be emitted.
REQ-025 Reset assertion SHALL take effect without a clock edge. Release SHALL be synchronous to clk_i by the integrating design.

Configuration
REQ-026 Macro STREAM_UNPACK_MSB_FIRST_EN: when defined, data_o SHALL be slice [(ratio_p-1-beat)*width_p +: width_p] (most-significant beat first).
REQ-027 When STREAM_UNPACK_MSB_FIRST_EN is undefined, beat order SHALL be LSB first per REQ-020. Handshake and timing SHALL be identical in both builds.

Verification (width_p=8, ratio_p=4 unless stated)
REQ-028 Single word 32'hAABBCCDD, ready_i=1: data_o = DD, CC, BB, AA on 4 consecutive cycles starting 1 cycle after accept, then valid_o=0.
REQ-029 Back-to-back words 32'h04030201 and 32'h08070605 with valid_i held high and ready_i=1: valid_o high for 8 consecutive cycles, data_o = 01..08, ready_o high on cycle 4.
REQ-030 Stall: ready_i=0 for 3 cycles during beat 1 of 32'hAABBCCDD: data_o holds CC, ready_o=0, and delivery resumes with BB.
REQ-031 Reset pulse after beat DD of 32'hAABBCCDD: valid_o=0 immediately. After release, the next word 32'h11223344 emits 44, 33, 22, 11 only.
REQ-032 STREAM_UNPACK_MSB_FIRST_EN defined, word 32'hAABBCCDD: data_o = AA, BB, CC, DD.
REQ-033 ratio_p=1, width_p=8, random valid_i/ready_i for 1000 cycles: output sequence equals input sequence with no loss or duplication.
